// File: rtl/alu_wb_stage.sv
// alu_wb_stage: writeback stage behind the 8-bit ALU.
// Results go into a 2-entry FIFO that drains to the register-file write port
// through a valid/ready handshake. Upstream operand fetch can look up results
// that are still queued through a combinational bypass. A sticky bit records
// overflow.
// Optional feature: define WB_OVF_COUNT_EN to add an 8-bit saturating counter
// of overflowing pushes on port ovf_count.
module alu_wb_stage #(
  parameter int DATA_W     = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  // ALU result input
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_ovf,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_we,
  // register-file write port
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  wb_we,
  // bypass lookup
  input  logic [REG_ADDR_W-1:0] byp_addr_a,
  input  logic [REG_ADDR_W-1:0] byp_addr_b,
  output logic                  byp_hit_a,
  output logic                  byp_hit_b,
  output logic [DATA_W-1:0]     byp_data_a,
  output logic [DATA_W-1:0]     byp_data_b,
  // overflow status
  input  logic                  ovf_clr,
  output logic                  status_ovf
`ifdef WB_OVF_COUNT_EN
  ,
  output logic [7:0]            ovf_count
`endif
);

  // Entry storage. The overflow flag is folded into the sticky status at push
  // time and is never observed at the write port, so entries do not carry it.
  logic [DATA_W-1:0]     data_q [2];
  logic [REG_ADDR_W-1:0] rd_q   [2];
  logic                  we_q   [2];

  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       status_ovf_q, status_ovf_d;

  logic push, pop, push_ovf;
  logic newest;

  // Ready depends only on registered occupancy, never on wb_ready.
  assign in_ready = (count_q != 2'd2) & ~rst;
  assign wb_valid = (count_q != 2'd0) & ~rst;

  assign push     = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;
  assign push_ovf = push & in_ovf;

  // Head entry is shown only while valid; otherwise the port reads as zero.
  assign wb_data = wb_valid ? data_q[head_q] : '0;
  assign wb_addr = wb_valid ? rd_q[head_q]   : '0;
  assign wb_we   = wb_valid & we_q[head_q];

  assign status_ovf = status_ovf_q;

  // Next-state for pointers, occupancy and sticky overflow.
  always_comb begin
    head_d = head_q ^ pop;
    tail_d = tail_q ^ push;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Set wins over a simultaneous clear.
    if (push_ovf)     status_ovf_d = 1'b1;
    else if (ovf_clr) status_ovf_d = 1'b0;
    else              status_ovf_d = status_ovf_q;
  end

  // Control registers with synchronous reset; queued entries are discarded.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples its inputs as they were before the clock edge.
    if (rst) begin
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      count_q      <= 2'd0;
      status_ovf_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      status_ovf_q <= status_ovf_d;
    end
  end

  // Entry write on push.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; stale contents are masked by
    // count_q, which keeps the storage plain flops without a reset tree.
    if (push) begin
      data_q[tail_q] <= in_data;
      rd_q[tail_q]   <= in_rd;
      we_q[tail_q]   <= in_we;
    end
  end

  // Newest valid entry sits one slot behind the tail.
  assign newest = ~tail_q;

  // Lookup over queued entries; the newer match overrides the older one.
  // Returns {hit, data}.
  function automatic logic [DATA_W:0] lookup(input logic [REG_ADDR_W-1:0] addr);
    logic [DATA_W:0] res;
    res = '0;
    if (!rst) begin
      if (count_q == 2'd2 && we_q[head_q] && rd_q[head_q] == addr)
        res = {1'b1, data_q[head_q]};
      if (count_q != 2'd0 && we_q[newest] && rd_q[newest] == addr)
        res = {1'b1, data_q[newest]};
    end
    return res;
  endfunction

  // Combinational bypass for both operands.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here via the function's default) so no latch is inferred.
    {byp_hit_a, byp_data_a} = lookup(byp_addr_a);
    {byp_hit_b, byp_data_b} = lookup(byp_addr_b);
  end

`ifdef WB_OVF_COUNT_EN
  logic [7:0] ovf_count_q, ovf_count_d;

  // Saturating overflow counter; an increment coinciding with clear gives 1.
  always_comb begin
    if (ovf_clr)
      ovf_count_d = push_ovf ? 8'd1 : 8'd0;
    else if (push_ovf && ovf_count_q != 8'hFF)
      ovf_count_d = ovf_count_q + 8'd1;
    else
      ovf_count_d = ovf_count_q;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) ovf_count_q <= 8'd0;
    else     ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule
